mem_block_copy: RTL and testbench
=================================

Name: mem_block_copy

Overview:
- Bus-initiator engine that drives the address/load/in side of a synchronous-read word RAM and consumes its data output.
- Performs block COPY (src to dst) or block FILL (constant to dst) of up to 2^ADDR_W words, started by a one-cycle start strobe.
- Sits between control logic (CPU-side or boot loader) and a data RAM instance.
- Handles the RAM's one-cycle registered read latency.

Parameters:
- ADDR_W, 3, RAM address width; RAM depth is 2^ADDR_W words.
- DATA_W, 16, word width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  1  0 = COPY, 1 = FILL.
- src_addr  input  ADDR_W  COPY source base address.
- dst_addr  input  ADDR_W  destination base address.
- len  input  ADDR_W+1  word count, 0..2^ADDR_W.
- fill_value  input  DATA_W  FILL data.
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle completion pulse.
- ram_address  output  ADDR_W  RAM address.
- ram_load  output  1  RAM write enable.
- ram_in  output  DATA_W  RAM write data.
- ram_out  input  DATA_W  RAM read data; holds mem[addr presented last cycle].

Interface rule (already decided): one clock, clk; reset is synchronous and active-high, port name reset.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset values: state IDLE; busy 0, done 0, ram_load 0, ram_address 0, ram_in 0; counters 0.
- ram_load is gated combinationally with !reset, so no RAM write occurs in any cycle where reset is high.
- IDLE:
  - outputs at reset values.
  - start=1: latch op, src, dst, len, fill_value.
  - len==0: go to DONE.
  - op=COPY: go to RD.
  - op=FILL: go to WR.
- RD (COPY only): ram_address = src+i, ram_load 0, busy 1; go to WR.
- WR:
  - ram_address = dst+i, ram_load 1, busy 1.
  - ram_in = ram_out for COPY; ram_in = latched fill_value for FILL.
  - Increment i.
  - If i+1 == len: go to DONE.
  - Else: go to RD (COPY) or stay in WR (FILL).
- DONE: done 1, busy 0, ram_load 0; go to IDLE. start is ignored in DONE.
- Address arithmetic: base + i modulo 2^ADDR_W (wraps; no error).
- Word counter i is ADDR_W+1 bits wide, so len = 2^ADDR_W is legal.
- Latency, start sampled at edge k:
  - COPY: first RD in cycle k+1, word j written in cycle k+2+2j, done in cycle k+1+2*len.
  - FILL: word j written in cycle k+1+j, done in cycle k+1+len.
  - len==0: done in cycle k+1, no RAM write.
- Overlap: words are processed strictly ascending, read immediately before write.
  - COPY result is sequential-forward semantics: dst[j] = mem[src+j] as it stands after words 0..j-1 are written.
  - Hence dst = src+1 replicates mem[src] across the block.
- start while busy or in DONE: ignored; latched command registers unchanged.
- Input changes after the start cycle: no effect.
- reset mid-command: next state IDLE, busy/done 0, no further writes; already-written words remain.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RD, WR, DONE);
  - op encodings OP_COPY = 0, OP_FILL = 1;
  - default ADDR_W / DATA_W constants.
- No sub-module: FSM, counter and address adders fit in one module.
- Bench instantiates the team's 8-word synchronous-read RAM as the target.

Test Plan:
- FILL: preload RAM 0..7 = 0; start op=1, dst=2, len=3, fill=16'hBEEF -> writes in cycles k+1..k+3 to addresses 2,3,4; done at k+4; RAM[2..4] = BEEF, others 0.
- COPY: RAM[i] = 16'h1000+i; start src=0, dst=4, len=4 -> RAM[4..7] = 1000..1003, RAM[0..3] unchanged; done exactly at k+9; busy high cycles k+1..k+8.
- Wrap and overlap:
  - COPY src=6, dst=1, len=3 from the pattern above -> RAM[1..3] = 1006, 1007, 1000.
  - COPY src=0, dst=1, len=3 -> RAM[1..3] all equal original RAM[0].
- len=0 and full length:
  - len=0 -> done at k+1, ram_load never asserted.
  - FILL len=8 -> all 8 words written, done at k+9.
- Start while busy: second start with different args during COPY -> ignored; final memory and done timing match the first command only.
- Reset mid-COPY: assert reset in the 3rd WR cycle -> ram_load low that cycle, busy/done 0 next cycle, only the first two destination words modified; a new command afterwards runs normally.

Source files
------------

// File: rtl/mem_block_copy_pkg.sv
// Shared constants for the block copy/fill engine: default widths, opcodes and FSM encodings.
package mem_block_copy_pkg;

    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_DATA_W = 16;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mem_block_copy_if.sv
// Command and RAM-side bus of the copy engine; master is the engine, slave is control plus RAM.
interface mem_block_copy_if
    import mem_block_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              start;
    logic              op;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_load;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_out;

    modport master (
        input  start, op, src_addr, dst_addr, len, fill_value, ram_out,
        output busy, done, ram_address, ram_load, ram_in
    );

    modport slave (
        output start, op, src_addr, dst_addr, len, fill_value, ram_out,
        input  busy, done, ram_address, ram_load, ram_in
    );

endinterface

// File: rtl/mem_block_copy.sv
// Block COPY/FILL engine driving a synchronous-read RAM; COPY alternates read and write cycles
// so each word is read immediately before it is written (sequential-forward overlap semantics).
module mem_block_copy
    import mem_block_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input logic               clk,
    input logic               reset,
    mem_block_copy_if.master  bus
);

    state_t            r_state;
    logic              r_op;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_fill;
    logic [ADDR_W:0]   r_cnt;

    logic [ADDR_W:0]   w_cnt_inc;
    logic [ADDR_W-1:0] w_idx;

    assign w_cnt_inc = r_cnt + (ADDR_W+1)'(1);
    assign w_idx     = r_cnt[ADDR_W-1:0];

    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.ram_address = '0;
        bus.ram_load    = 1'b0;
        bus.ram_in      = '0;
        case (r_state)
            ST_RD: begin
                bus.busy        = 1'b1;
                bus.ram_address = r_src + w_idx;
            end
            ST_WR: begin
                bus.busy        = 1'b1;
                bus.ram_address = r_dst + w_idx;
                // Gated so an asserted reset blocks the write in the very cycle it appears.
                bus.ram_load    = !reset;
                bus.ram_in      = (r_op == OP_FILL) ? r_fill : bus.ram_out;
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_COPY;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op   <= bus.op;
                        r_src  <= bus.src_addr;
                        r_dst  <= bus.dst_addr;
                        r_len  <= bus.len;
                        r_fill <= bus.fill_value;
                        r_cnt  <= '0;
                        if (bus.len == '0) begin
                            r_state <= ST_DONE;
                        end else if (bus.op == OP_FILL) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: r_state <= ST_WR;
                ST_WR: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        r_state <= ST_DONE;
                    end else if (r_op == OP_COPY) begin
                        r_state <= ST_RD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_copy.sv
// Bench for mem_block_copy: behavioural 8-word sync-read RAM, command table plus corner sequences,
// and a write scoreboard filled from a sequential-forward reference model.
module tb_mem_block_copy;
    import mem_block_copy_pkg::*;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic        op;
        int          src;
        int          dst;
        int          len;
        logic [15:0] fill;
        int          pat;
    } vec_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_block_copy_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_block_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] pre_img [DEPTH];
    logic          pre_go;

    always @(posedge clk) begin
        if (pre_go) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pre_img[i];
        end else if (bus.ram_load) begin
            ram[bus.ram_address] <= bus.ram_in;
        end
        bus.ram_out <= ram[bus.ram_address];
    end

    int          n_cmp = 0;
    int          n_err = 0;
    wr_t         exp_q[$];
    logic [15:0] exp_mem [DEPTH];
    vec_t        vecs [8];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < DEPTH; i++) begin
            pre_img[i] = (pat == 1) ? 16'(32'h1000 + i) : 16'h0000;
            exp_mem[i] = pre_img[i];
        end
        @(negedge clk);
        pre_go = 1'b1;
        @(negedge clk);
        pre_go = 1'b0;
    endtask

    // Reference: ascending words, each read after all earlier writes landed.
    task automatic build_model(input vec_t v, input int limit);
        int a;
        logic [15:0] d;
        for (int j = 0; j < v.len && j < limit; j++) begin
            a = (v.dst + j) % DEPTH;
            d = v.op ? v.fill : exp_mem[(v.src + j) % DEPTH];
            exp_mem[a] = d;
            exp_q.push_back('{addr: a, data: d});
        end
    endtask

    task automatic run(input vec_t v, input int inj_at, input int rst_at, input int limit);
        int  exp_done;
        int  done_at;
        int  busy_cnt;
        wr_t w;
        exp_done = (v.len == 0) ? 1 : (v.op ? v.len + 1 : 2 * v.len + 1);
        done_at  = 0;
        busy_cnt = 0;
        load_pattern(v.pat);
        build_model(v, limit);
        @(negedge clk);
        bus.op         = v.op;
        bus.src_addr   = AW'(v.src);
        bus.dst_addr   = AW'(v.dst);
        bus.len        = (AW+1)'(v.len);
        bus.fill_value = v.fill;
        bus.start      = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.start = 1'b0;
            if (c == inj_at) begin
                bus.start      = 1'b1;
                bus.op         = OP_FILL;
                bus.src_addr   = 3'd3;
                bus.dst_addr   = 3'd0;
                bus.len        = 4'd8;
                bus.fill_value = 16'hDEAD;
            end
            if (c == inj_at + 1) bus.start = 1'b0;
            if (c == rst_at) reset = 1'b1;
            if (c == rst_at + 1) reset = 1'b0;
            @(negedge clk);
            if (reset) check("load_during_reset", int'(bus.ram_load), 0);
            if (bus.ram_load) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", int'(bus.ram_address), -1);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", int'(bus.ram_address), w.addr);
                    check("wr_data", int'(bus.ram_in), int'(w.data));
                end
            end
            if (bus.busy) busy_cnt++;
            if (rst_at > 0 && c == rst_at + 1) begin
                check("busy_after_reset", int'(bus.busy), 0);
                check("done_after_reset", int'(bus.done), 0);
                break;
            end
            if (bus.done) begin
                done_at = c;
                break;
            end
            if (c == 40) check("done_timeout", 0, 1);
        end
        check("writes_outstanding", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        if (rst_at == 0) begin
            check("done_cycle", done_at, exp_done);
            check("busy_cycles", busy_cnt, exp_done - 1);
            check("done_one_cycle", int'(bus.done), 0);
        end
        for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), int'(ram[i]), int'(exp_mem[i]));
    endtask

    initial begin
        reset          = 1'b1;
        pre_go         = 1'b0;
        bus.start      = 1'b0;
        bus.op         = 1'b0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.len        = '0;
        bus.fill_value = '0;

        vecs[0] = '{op: OP_FILL, src: 0, dst: 2, len: 3, fill: 16'hBEEF, pat: 0};
        vecs[1] = '{op: OP_COPY, src: 0, dst: 4, len: 4, fill: 16'h0000, pat: 1};
        vecs[2] = '{op: OP_COPY, src: 6, dst: 1, len: 3, fill: 16'h0000, pat: 1};
        vecs[3] = '{op: OP_COPY, src: 0, dst: 1, len: 3, fill: 16'h0000, pat: 1};
        vecs[4] = '{op: OP_COPY, src: 2, dst: 5, len: 0, fill: 16'h0000, pat: 1};
        vecs[5] = '{op: OP_FILL, src: 0, dst: 0, len: 8, fill: 16'h5A5A, pat: 1};
        vecs[6] = '{op: OP_COPY, src: 3, dst: 5, len: 8, fill: 16'h0000, pat: 1};
        vecs[7] = '{op: OP_FILL, src: 0, dst: 7, len: 2, fill: 16'h1234, pat: 0};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_load", int'(bus.ram_load), 0);
        check("rst_addr", int'(bus.ram_address), 0);
        check("rst_in", int'(bus.ram_in), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_load", int'(bus.ram_load), 0);

        for (int i = 0; i < 8; i++) run(vecs[i], 0, 0, 999);

        // A second start mid-COPY must not disturb the first command.
        run(vecs[1], 3, 0, 999);

        // Reset in the third WR cycle of a COPY: only two destination words land.
        run(vecs[1], 6, 6, 2);
        run(vecs[3], 0, 0, 999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
